// File: rtl/adc0_frame_sender.sv
// adc0_frame_sender: drains the channel-0 capture FIFO into a framed, checksummed byte stream
module adc0_frame_sender #(
  parameter int unsigned FRAME_LEN = 1024,
  parameter logic [7:0]  CHAN_ID   = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_q_i,
  output logic       fifo_rdreq_o,
  output logic       fifo_sclr_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       underrun_o
);
  localparam logic [15:0] LEN = 16'(FRAME_LEN);
  typedef enum logic [3:0] {IDLE, HDR0, HDR1, CHAN, LENH, LENL, RD, WAITQ, DATA, CSUM, CLEAR} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  sample_q, sample_d;
  logic        rd_q, rd_d;
  logic        under_q, under_d;
  logic        fire;
  assign fire         = tx_valid_o & tx_ready_i;
  assign tx_valid_o   = state_q inside {HDR0, HDR1, CHAN, LENH, LENL, DATA, CSUM};
  assign fifo_rdreq_o = (state_q == RD) & ~fifo_empty_i;
  assign fifo_sclr_o  = state_q == CLEAR;
  assign frame_done_o = state_q == CLEAR;
  assign busy_o       = state_q != IDLE;
  assign underrun_o   = under_q;
  // Outgoing byte chosen by the current state; zero whenever nothing is offered
  always_comb begin
    tx_data_o = 8'h00;
    case (state_q)
      HDR0:    tx_data_o = 8'hA5;
      HDR1:    tx_data_o = 8'h5A;
      CHAN:    tx_data_o = CHAN_ID;
      LENH:    tx_data_o = LEN[15:8];
      LENL:    tx_data_o = LEN[7:0];
      DATA:    tx_data_o = sample_q;
      CSUM:    tx_data_o = csum_q;
      default: tx_data_o = 8'h00;
    endcase
  end
  // Frame sequencing: header bytes advance on transfer, each sample is read, latched, then offered
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    sample_d = sample_q;
    rd_d     = rd_q;
    under_d  = under_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = HDR0;
        cnt_d   = '0;
        csum_d  = '0;
        under_d = 1'b0;
      end
      HDR0: if (fire) state_d = HDR1;
      HDR1: if (fire) state_d = CHAN;
      CHAN: if (fire) begin
        state_d = LENH;
        csum_d  = csum_q + CHAN_ID;
      end
      LENH: if (fire) begin
        state_d = LENL;
        csum_d  = csum_q + LEN[15:8];
      end
      LENL: if (fire) begin
        state_d = RD;
        csum_d  = csum_q + LEN[7:0];
      end
      RD: begin
        rd_d    = ~fifo_empty_i;
        under_d = under_q | fifo_empty_i;
        state_d = WAITQ;
      end
      WAITQ: begin
        sample_d = rd_q ? fifo_q_i : 8'h00;
        csum_d   = csum_q + sample_d;
        state_d  = DATA;
      end
      DATA: if (fire) begin
        cnt_d   = cnt_q + 16'd1;
        state_d = (cnt_q + 16'd1 == LEN) ? CSUM : RD;
      end
      CSUM:    if (fire) state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset leaves the FIFO untouched
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      csum_q   <= '0;
      sample_q <= '0;
      rd_q     <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      sample_q <= sample_d;
      rd_q     <= rd_d;
      under_q  <= under_d;
    end
  end
endmodule
